pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the branch resolver: owns the PC and the

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pc_next_sel.sv | 28 ++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction width, PC step and fetch FSM states.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage: reset > redirect > stall > sequential step.
module pc_next_sel import cpu_pkg::*; #(
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                reset_i,
    input  logic                pcsrc_i,
    input  logic                stall_i,
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] target_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    // Redirect targets are word-aligned by clearing the two byte-offset bits.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    always_comb begin
        pc_next_o = pc_i + PC_WIDTH'(PC_INC);
        if (reset_i) begin
            pc_next_o = RESET_PC;
        end else if (pcsrc_i) begin
            pc_next_o = target_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_next_o = pc_i;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle imem port and feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/squash performance counters.
module pc_fetch_unit import cpu_pkg::*; #(
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                pcsrc,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [INSTR_W-1:0]  if_instr,
    output logic                if_valid,
    output logic                flush_if_id,
    output logic                flush_id_ex,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_squash_cnt,
`endif
    output fetch_state_e        dbg_state
);

    // Handshake: if_valid qualifies {if_pc, if_instr}; IF/ID takes it on a cycle with
    // stall=0; a redirect (pcsrc) squashes it and the following fetch via flush strobes.

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    fetch_state_e        state_q, state_d;

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_next_sel (
        .reset_i   (reset),
        .pcsrc_i   (pcsrc),
        .stall_i   (stall),
        .pc_i      (pc_q),
        .target_i  (branch_target),
        .pc_next_o (pc_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            state_q  <= FILL;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            state_q  <= state_d;
        end
    end

    // Every state advances the same way; the state only decides whether rdata is on-path.
    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        imem_en     = 1'b0;
        if_valid    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (pcsrc) begin
            state_d = BUBBLE;
        end else if (!stall) begin
            req_pc_d = pc_q;
            state_d  = RUN;
        end
        if (!reset) begin
            flush_if_id = pcsrc;
            flush_id_ex = pcsrc;
            imem_en     = !pcsrc && !stall;
            if_valid    = (state_q == RUN);
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = req_pc_q;
    assign if_instr  = imem_rdata;
    assign dbg_state = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (if_valid && !stall && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (pcsrc && (squash_cnt_q != 32'hFFFF_FFFF)) begin
            squash_cnt_d = squash_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: program-order scoreboard plus per-cycle port rules.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = '0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, stall, pcsrc;
  logic [W-1:0] branch_target, imem_addr, if_pc;
  logic imem_en, if_valid, flush_if_id, flush_id_ex;
  logic [31:0] imem_rdata, if_instr;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_squash_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_WIDTH(W), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_en       (imem_en),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_valid      (if_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_squash_cnt (perf_squash_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // Instruction memory: content is a fixed function of the address, read takes 1 cycle.
  function automatic logic [31:0] instr_of(input logic [W-1:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= instr_of(imem_addr);
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_fail = 0;
  int n_deliv = 0;
  logic [W+31:0] exp_q[$];
  logic [W-1:0] model_next;   // next program-order address to enqueue
  logic [W-1:0] model_addr;   // address the fetch port should present this cycle
  logic bubble_pend;          // no correct-path instruction available yet
  logic [31:0] m_fetch, m_squash;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 2) begin
      exp_q.push_back({model_next, instr_of(model_next)});
      model_next = model_next + 32'd4;
    end
  endtask

  // Per-cycle rules, sampled at negedge after inputs settle.
  task automatic sample_checks();
    check("flush_if_id", flush_if_id, pcsrc);
    check("flush_id_ex", flush_id_ex, pcsrc);
    check("imem_en", imem_en, !(stall || pcsrc));
    check("imem_addr", imem_addr, model_addr);
    check("if_valid", if_valid, !bubble_pend);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    check("perf_squash_cnt", perf_squash_cnt, m_squash);
`endif
    if (!bubble_pend && !stall) m_fetch = m_fetch + 32'd1;
    if (pcsrc) m_squash = m_squash + 32'd1;
    if (pcsrc) begin
      model_addr  = branch_target & ~32'h3;
      bubble_pend = 1'b1;
    end else if (!stall) begin
      model_addr  = model_addr + 32'd4;
      bubble_pend = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic s, input logic p, input logic [W-1:0] t);
    @(posedge clk);
    #1;
    stall = s;
    pcsrc = p;
    branch_target = t;
    if (p) begin
      exp_q.delete();
      model_next = t & ~32'h3;
    end
    topup();
    @(negedge clk);
    sample_checks();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    stall = 1'b0;
    pcsrc = 1'b0;
    reset = 1'b0;
    model_addr  = RST_PC;
    bubble_pend = 1'b1;
    exp_q.delete();
    model_next = RST_PC;
    topup();
    m_fetch = '0;
    m_squash = '0;
    @(negedge clk);
    sample_checks();
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_en", imem_en, 1'b0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_flush_if_id", flush_if_id, 1'b0);
    check("rst_flush_id_ex", flush_id_ex, 1'b0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_if_pc", if_pc, RST_PC);
    check("rst_state", dbg_state, FILL);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    check("rst_perf_squash", perf_squash_cnt, 32'd0);
`endif
  endtask

  // ---------------- monitor ----------------
  // A correct-path instruction is consumed when valid, not stalled and not squashed.
  always @(negedge clk) begin
    logic [W+31:0] e;
    if (!reset && if_valid && !stall && !pcsrc) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL deliver: got pc %h with nothing expected", if_pc);
      end else begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e[W+31:32]);
        check("if_instr", if_instr, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    stall = 1'b0;
    pcsrc = 1'b0;
    branch_target = '0;
    #12;
    check_reset_outputs();
    release_reset();

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h100);                               // plain redirect
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);        // 3-cycle stall
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h200);                               // redirect beats stall
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h40);                                // back-to-back redirects
    cycle(1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h103);                               // misaligned target
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);                         // PC wrap
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);

    for (int i = 0; i < 3000; i++) begin
      logic s, p;
      logic [W-1:0] t;
      s = ($urandom_range(0, 4) == 0);
      p = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(s, p, t);
    end

    // Async reset in the middle of a bubble cycle.
    cycle(1'b0, 1'b1, 32'h0000_1234);
    cycle(1'b0, 1'b0, '0);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    release_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);

    check("deliveries_seen", (n_deliv > 100), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
